// File: rtl/bitnet_pkg.sv
// Shared types, default geometry and the per-lane vote rule for the bitnet unit array.
package bitnet_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned ACC_W_DEF  = 4;
  localparam int unsigned THRESH_DEF = 8;

  // Lane vector at the default lane count; wider arrays use logic [N-1:0] directly.
  typedef logic [LANES-1:0] lane_vec_t;

  // Result of one backward vote on a lane: flip request plus the counter's next value.
  typedef struct packed {
    logic        flip;
    logic [31:0] cnt;
  } vote_t;

  // One lane's backward vote.
  //   s=1, bin=1 : count up; reaching THRESH flips the weight and clears the counter.
  //   s=1, bin=0 : count down, floored at zero.
  //   s=0        : the lane took no part in the forward pass, so the counter holds.
  function automatic vote_t flip_vote(logic s, logic bin, logic [31:0] cnt, logic [31:0] thresh);
    vote_t v;
    v.flip = 1'b0;
    v.cnt  = cnt;
    if (s) begin
      if (bin) begin
        if (cnt == thresh - 32'd1) begin
          v.flip = 1'b1;
          v.cnt  = 32'd0;
        end else begin
          v.cnt = cnt + 32'd1;
        end
      end else if (cnt != 32'd0) begin
        v.cnt = cnt - 32'd1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/bitnet_unit_array_if.sv
// Forward/backward strobe bus of the bitnet unit array.
// BITNET_UNIT_WLOAD_EN adds the wload/wload_data weight-load lines.
interface bitnet_unit_array_if
  import bitnet_pkg::*;
#(
  parameter int unsigned N = LANES
);

  logic         fd_prop;
  logic [N-1:0] fin;
  logic         fd_ready;
  logic [N-1:0] fout;
  logic         fout_valid;
  logic         bk_prop;
  logic [N-1:0] bin;
  logic [N-1:0] bout;
  logic         bout_valid;
  logic [N-1:0] weights;
  logic         bk_underrun;
`ifdef BITNET_UNIT_WLOAD_EN
  logic         wload;
  logic [N-1:0] wload_data;
`endif

  // Upstream/downstream driver side.
  modport master (
    output fd_prop,
    output fin,
    output bk_prop,
    output bin,
`ifdef BITNET_UNIT_WLOAD_EN
    output wload,
    output wload_data,
`endif
    input  fd_ready,
    input  fout,
    input  fout_valid,
    input  bout,
    input  bout_valid,
    input  weights,
    input  bk_underrun
  );

  // Unit array side.
  modport slave (
    input  fd_prop,
    input  fin,
    input  bk_prop,
    input  bin,
`ifdef BITNET_UNIT_WLOAD_EN
    input  wload,
    input  wload_data,
`endif
    output fd_ready,
    output fout,
    output fout_valid,
    output bout,
    output bout_valid,
    output weights,
    output bk_underrun
  );

endinterface

// File: rtl/bitnet_grad_accum.sv
// One lane of the bitnet unit: saturating gradient counter, weight bit and flip strobe.
module bitnet_grad_accum
  import bitnet_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned THRESH = THRESH_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en,          // backward pass accepted this cycle
  input  logic s,           // stashed forward input bit for this lane
  input  logic e,           // error bit for this lane
  input  logic wload,
  input  logic wload_data,
  output logic w,
  output logic flip         // weight flips at this edge
);

  logic [ACC_W-1:0] cnt_q;
  logic             w_q;
  vote_t            vote;

  // Vote on the current counter; only consumed when a backward pass is accepted.
  always_comb begin
    vote = flip_vote(s, e, 32'(cnt_q), 32'(THRESH));
  end

  // A weight load overrides the vote, so no flip is reported that cycle.
  assign flip = en & ~wload & vote.flip;
  assign w    = w_q;

  // Counter and weight state; load beats vote, vote only on accepted backward passes.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
      w_q   <= 1'b0;
    end else if (wload) begin
      cnt_q <= '0;
      w_q   <= wload_data;
    end else if (en) begin
      cnt_q <= ACC_W'(vote.cnt);
      if (vote.flip) begin
        w_q <= ~w_q;
      end
    end
  end

endmodule

// File: rtl/bitnet_unit_array.sv
// N-lane binary unit (one bitnet layer slice): forward XOR with per-lane weights, a stash of
// in-flight forward inputs, and backward error gating that flips weights once enough errors
// accumulate on a lane. BITNET_UNIT_WLOAD_EN adds a direct weight-load path.
module bitnet_unit_array
  import bitnet_pkg::*;
#(
  parameter int unsigned N      = LANES,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned THRESH = THRESH_DEF
) (
  input logic                clk_in,
  input logic                rst_in,
  bitnet_unit_array_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [N-1:0]    stash_q [DEPTH];
  logic [PtrW-1:0] head_q;
  logic [PtrW-1:0] tail_q;
  logic [CntW-1:0] count_q;

  logic            full;
  logic            empty;
  logic            fd_acc;
  logic            bk_acc;
  logic [N-1:0]    head_s;

  logic [N-1:0]    weights;
  logic [N-1:0]    flip;
  logic            wload;
  logic [N-1:0]    wload_data;

  logic [N-1:0]    fout_q;
  logic            fout_valid_q;
  logic [N-1:0]    bout_q;
  logic            bout_valid_q;
  logic            underrun_q;

`ifdef BITNET_UNIT_WLOAD_EN
  assign wload      = bus.wload;
  assign wload_data = bus.wload_data;
`else
  assign wload      = 1'b0;
  assign wload_data = '0;
`endif

  // Acceptance depends on registered occupancy only, so a full stash rejects a forward
  // strobe even if a backward pop happens on the same edge.
  assign full   = (count_q == CntW'(DEPTH));
  assign empty  = (count_q == '0);
  assign fd_acc = bus.fd_prop & ~full;
  assign bk_acc = bus.bk_prop & ~empty;
  assign head_s = stash_q[head_q];

  // Stash payload; no reset needed since occupancy is tracked by count_q.
  always_ff @(posedge clk_in) begin
    if (fd_acc) begin
      stash_q[tail_q] <= bus.fin;
    end
  end

  // Stash pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (fd_acc) begin
        tail_q <= tail_q + 1'b1;
      end
      if (bk_acc) begin
        head_q <= head_q + 1'b1;
      end
      case ({fd_acc, bk_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Per-lane gradient counters and weight bits.
  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    bitnet_grad_accum #(
      .ACC_W  (ACC_W),
      .THRESH (THRESH)
    ) u_accum (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .en         (bk_acc),
      .s          (head_s[i]),
      .e          (bus.bin[i]),
      .wload      (wload),
      .wload_data (wload_data[i]),
      .w          (weights[i]),
      .flip       (flip[i])
    );
  end

  // Forward result uses the weights from before this edge's flips or load.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      fout_q       <= '0;
      fout_valid_q <= 1'b0;
    end else begin
      fout_valid_q <= fd_acc;
      if (fd_acc) begin
        fout_q <= bus.fin ^ weights;
      end
    end
  end

  // Backward error passes upstream except on lanes whose weight this pass corrected.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bout_q       <= '0;
      bout_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      bout_valid_q <= bk_acc;
      if (bk_acc) begin
        bout_q <= bus.bin & ~flip;
      end
      if (bus.bk_prop && empty) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign bus.fd_ready    = ~full;
  assign bus.fout        = fout_q;
  assign bus.fout_valid  = fout_valid_q;
  assign bus.bout        = bout_q;
  assign bus.bout_valid  = bout_valid_q;
  assign bus.weights     = weights;
  assign bus.bk_underrun = underrun_q;

endmodule
